ras_ctrl: RTL and testbench

- Speculation controller for the return address stack (RAS).
- Sits between fetch-side prediction and the RAS. Classifies predicted calls and returns and issues RAS push/pop commands.
- Keeps an in-order checkpoint queue holding a snapshot {stack_ptr, top address} for every in-flight call/return.
- On a mispredict it discards wrong-path checkpoints and drives a one-cycle restore of the RAS pointer and top entry.

---
 rtl/ras_ctrl_if.sv | 42 ++++
 rtl/ras_ctrl.sv | 114 +++++++++++
 tb/tb_ras_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ras_ctrl_if.sv
// Fetch-prediction / RAS / resolution signal bundle for the RAS speculation controller.
// master drives predictions, RAS state, commits and mispredicts; slave is the controller.
interface ras_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int PTR_W = 3,
    parameter int TAG_W = 3
);
    logic               pred_valid;
    logic               pred_ready;
    logic [6:0]         pred_opcode;
    logic [4:0]         pred_rd;
    logic [4:0]         pred_rs1;
    logic [XLEN-1:0]    pred_pc;
    logic               pred_is_ckpt;
    logic [TAG_W-1:0]   pred_tag;
    logic [PTR_W-1:0]   ras_ptr_in;
    logic [XLEN-1:0]    ras_top_in;
    logic               ras_push_en;
    logic [XLEN-1:0]    ras_push_addr;
    logic               ras_pop_en;
    logic               ras_restore_valid;
    logic [PTR_W-1:0]   ras_restore_ptr;
    logic [XLEN-1:0]    ras_restore_top;
    logic               commit_valid;
    logic               mispredict_valid;
    logic [TAG_W-1:0]   mispredict_tag;
    logic [TAG_W:0]     ckpt_count;

    modport master (
        output pred_valid, pred_opcode, pred_rd, pred_rs1, pred_pc,
               ras_ptr_in, ras_top_in, commit_valid, mispredict_valid, mispredict_tag,
        input  pred_ready, pred_is_ckpt, pred_tag, ras_push_en, ras_push_addr, ras_pop_en,
               ras_restore_valid, ras_restore_ptr, ras_restore_top, ckpt_count
    );

    modport slave (
        input  pred_valid, pred_opcode, pred_rd, pred_rs1, pred_pc,
               ras_ptr_in, ras_top_in, commit_valid, mispredict_valid, mispredict_tag,
        output pred_ready, pred_is_ckpt, pred_tag, ras_push_en, ras_push_addr, ras_pop_en,
               ras_restore_valid, ras_restore_ptr, ras_restore_top, ckpt_count
    );
endinterface

// File: rtl/ras_ctrl.sv
// RAS speculation controller: issues push/pop for calls/returns, checkpoints RAS state, restores on mispredict.
// Latency: push/pop same cycle as acceptance; restore pulse one cycle after the mispredict edge.
// Backpressure: pred_ready drops for calls/returns when the checkpoint queue is full, and for all during RECOVER.
module ras_ctrl #(
    parameter int XLEN       = 32,
    parameter int PTR_W      = 3,
    parameter int CKPT_DEPTH = 8,
    parameter int TAG_W      = 3
) (
    input  logic      clk,
    input  logic      reset_n,
    ras_ctrl_if.slave bus
);
    typedef enum logic {RUN, RECOVER} state_t;

    typedef struct packed {
        logic [PTR_W-1:0] ptr;
        logic [XLEN-1:0]  top;
    } ckpt_t;

    localparam logic [6:0]     OP_JAL   = 7'b1101111;
    localparam logic [6:0]     OP_JALR  = 7'b1100111;
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(CKPT_DEPTH);

    state_t           state_q, state_d;
    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    ckpt_t            ckpt_mem [CKPT_DEPTH];
    logic             restore_vld_q;
    ckpt_t            restore_q;

    logic             rd_link, rs1_link, is_call, is_ret, full;
    logic             ready, accept, alloc, commit_eff, mp_take;
    logic [TAG_W-1:0] head_c, mp_off;
    logic [TAG_W:0]   count_c;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    always_comb begin
        rd_link    = is_link(bus.pred_rd);
        rs1_link   = is_link(bus.pred_rs1);
        is_call    = ((bus.pred_opcode == OP_JAL) || (bus.pred_opcode == OP_JALR)) && rd_link;
        is_ret     = (bus.pred_opcode == OP_JALR) && rs1_link && !rd_link;
        full       = (count_q == FULL_CNT);
        ready      = (state_q == RUN) && !(full && (is_call || is_ret));
        accept     = bus.pred_valid && ready;
        alloc      = accept && (is_call || is_ret);
        commit_eff = bus.commit_valid && (count_q != '0);
        // Commit retires first, so the mispredict tag is checked against the post-commit window.
        head_c     = head_q + TAG_W'(commit_eff);
        count_c    = count_q - (TAG_W+1)'(commit_eff);
        mp_off     = bus.mispredict_tag - head_c;
        mp_take    = (state_q == RUN) && bus.mispredict_valid && ({1'b0, mp_off} < count_c);

        state_d = state_q;
        head_d  = head_c;
        tail_d  = tail_q;
        count_d = count_c;
        case (state_q)
            RUN: begin
                if (mp_take) begin
                    // Any same-cycle allocation is younger than the target and is dropped too.
                    state_d = RECOVER;
                    tail_d  = bus.mispredict_tag;
                    count_d = {1'b0, mp_off};
                end else if (alloc) begin
                    tail_d  = tail_q + 1'b1;
                    count_d = count_c + 1'b1;
                end
            end
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            restore_vld_q <= 1'b0;
            restore_q     <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            restore_vld_q <= mp_take;
            if (mp_take) begin
                restore_q <= ckpt_mem[bus.mispredict_tag];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ckpt_mem[tail_q] <= '{ptr: bus.ras_ptr_in, top: bus.ras_top_in};
        end
    end

    assign bus.pred_ready        = ready;
    assign bus.pred_is_ckpt      = alloc;
    assign bus.pred_tag          = alloc ? tail_q : '0;
    assign bus.ras_push_en       = accept && is_call;
    assign bus.ras_push_addr     = (accept && is_call) ? (bus.pred_pc + XLEN'(4)) : '0;
    assign bus.ras_pop_en        = accept && is_ret;
    assign bus.ras_restore_valid = restore_vld_q;
    assign bus.ras_restore_ptr   = restore_vld_q ? restore_q.ptr : '0;
    assign bus.ras_restore_top   = restore_vld_q ? restore_q.top : '0;
    assign bus.ckpt_count        = count_q;
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: classification, full-queue backpressure, wrap, restore, commit/mispredict races, reset.
module tb_ras_ctrl;
    localparam int XLEN       = 32;
    localparam int PTR_W      = 3;
    localparam int CKPT_DEPTH = 8;
    localparam int TAG_W      = 3;
    localparam logic [6:0] OP_JAL  = 7'h6f;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_ADD  = 7'h33;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    ras_ctrl_if #(.XLEN(XLEN), .PTR_W(PTR_W), .TAG_W(TAG_W)) bus();

    ras_ctrl #(.XLEN(XLEN), .PTR_W(PTR_W), .CKPT_DEPTH(CKPT_DEPTH), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pred_valid       = 1'b0;
        bus.pred_opcode      = '0;
        bus.pred_rd          = '0;
        bus.pred_rs1         = '0;
        bus.pred_pc          = '0;
        bus.commit_valid     = 1'b0;
        bus.mispredict_valid = 1'b0;
        bus.mispredict_tag   = '0;
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [31:0] pc, input logic [2:0] ptr, input logic [31:0] top);
        bus.pred_valid  = 1'b1;
        bus.pred_opcode = op;
        bus.pred_rd     = rd;
        bus.pred_rs1    = rs1;
        bus.pred_pc     = pc;
        bus.ras_ptr_in  = ptr;
        bus.ras_top_in  = top;
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        bus.pred_valid       = 1'b0;
        bus.pred_opcode      = '0;
        bus.pred_rd          = '0;
        bus.pred_rs1         = '0;
        bus.pred_pc          = '0;
        bus.ras_ptr_in       = '0;
        bus.ras_top_in       = '0;
        bus.commit_valid     = 1'b0;
        bus.mispredict_valid = 1'b0;
        bus.mispredict_tag   = '0;
        #2;
        chk("rst_ready",   bus.pred_ready, 1);
        chk("rst_count",   bus.ckpt_count, 0);
        chk("rst_push",    bus.ras_push_en, 0);
        chk("rst_pop",     bus.ras_pop_en, 0);
        chk("rst_restore", bus.ras_restore_valid, 0);
        chk("rst_is_ckpt", bus.pred_is_ckpt, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;

        // Call: JAL x1 at 0x100
        drive(OP_JAL, 5'd1, 5'd0, 32'h100, 3'd0, 32'h0);
        chk("call_push",    bus.ras_push_en, 1);
        chk("call_addr",    bus.ras_push_addr, 32'h104);
        chk("call_is_ckpt", bus.pred_is_ckpt, 1);
        chk("call_tag",     bus.pred_tag, 0);
        chk("call_nopop",   bus.ras_pop_en, 0);
        tick(); idle();
        chk("call_count", bus.ckpt_count, 1);

        // Return: JALR x0, x1 with ptr 2
        drive(OP_JALR, 5'd0, 5'd1, 32'h200, 3'd2, 32'h555);
        chk("ret_pop",    bus.ras_pop_en, 1);
        chk("ret_nopush", bus.ras_push_en, 0);
        chk("ret_tag",    bus.pred_tag, 1);
        tick(); idle();
        chk("ret_count", bus.ckpt_count, 2);

        // JALR x1, x1 is a call only
        drive(OP_JALR, 5'd1, 5'd1, 32'h300, 3'd3, 32'h666);
        chk("both_push",  bus.ras_push_en, 1);
        chk("both_nopop", bus.ras_pop_en, 0);
        chk("both_addr",  bus.ras_push_addr, 32'h304);
        chk("both_tag",   bus.pred_tag, 2);
        tick(); idle();
        chk("both_count", bus.ckpt_count, 3);

        // Mispredict on the return's tag restores the pointer it captured
        bus.mispredict_valid = 1'b1;
        bus.mispredict_tag   = 3'd1;
        tick(); idle();
        chk("mpr_valid", bus.ras_restore_valid, 1);
        chk("mpr_ptr",   bus.ras_restore_ptr, 2);
        chk("mpr_top",   bus.ras_restore_top, 32'h555);
        chk("mpr_count", bus.ckpt_count, 1);
        drive(OP_JAL, 5'd1, 5'd0, 32'h400, 3'd0, 32'h0);
        chk("mpr_ready", bus.pred_ready, 0);
        chk("mpr_push",  bus.ras_push_en, 0);
        tick(); idle();
        chk("mpr_done",  bus.ras_restore_valid, 0);
        chk("mpr_run",   bus.pred_ready, 1);
        chk("mpr_count2", bus.ckpt_count, 1);

        // Fill all eight checkpoints
        do_reset();
        for (int i = 0; i < CKPT_DEPTH; i++) begin
            drive(OP_JAL, 5'd5, 5'd0, 32'h1000 + 32'(i * 16), 3'(i), 32'h2000 + 32'(i));
            chk("fill_tag", bus.pred_tag, 64'(i));
            tick();
        end
        idle();
        chk("full_count", bus.ckpt_count, 8);
        drive(OP_JAL, 5'd1, 5'd0, 32'h500, 3'd0, 32'h0);
        chk("full_call_ready", bus.pred_ready, 0);
        chk("full_call_push",  bus.ras_push_en, 0);
        drive(OP_ADD, 5'd1, 5'd2, 32'h504, 3'd0, 32'h0);
        chk("full_add_ready", bus.pred_ready, 1);
        chk("full_add_ckpt",  bus.pred_is_ckpt, 0);
        tick(); idle();
        chk("full_add_count", bus.ckpt_count, 8);
        bus.commit_valid = 1'b1;
        tick(); idle();
        chk("commit_count", bus.ckpt_count, 7);
        drive(OP_JAL, 5'd1, 5'd0, 32'h600, 3'd0, 32'h0);
        chk("wrap_ready", bus.pred_ready, 1);
        chk("wrap_tag",   bus.pred_tag, 0);
        tick(); idle();
        chk("wrap_count", bus.ckpt_count, 8);
        bus.commit_valid = 1'b1;
        tick(); idle();
        drive(OP_JAL, 5'd1, 5'd0, 32'h700, 3'd0, 32'h0);
        bus.commit_valid = 1'b1;
        #1;
        chk("cmal_tag", bus.pred_tag, 1);
        tick(); idle();
        chk("cmal_count", bus.ckpt_count, 7);

        // Restore of tag 1 in a four-entry window
        do_reset();
        drive(OP_JAL,  5'd1, 5'd0, 32'h100, 3'd1, 32'h111); tick();
        drive(OP_JAL,  5'd1, 5'd0, 32'h104, 3'd3, 32'h200); tick();
        drive(OP_JALR, 5'd0, 5'd1, 32'h108, 3'd4, 32'h300); tick();
        drive(OP_JAL,  5'd1, 5'd0, 32'h10c, 3'd3, 32'h400); tick();
        idle();
        chk("win_count", bus.ckpt_count, 4);
        bus.mispredict_valid = 1'b1;
        bus.mispredict_tag   = 3'd1;
        tick(); idle();
        chk("rst1_valid", bus.ras_restore_valid, 1);
        chk("rst1_ptr",   bus.ras_restore_ptr, 3);
        chk("rst1_top",   bus.ras_restore_top, 32'h200);
        chk("rst1_ready", bus.pred_ready, 0);
        chk("rst1_count", bus.ckpt_count, 1);
        tick();
        chk("rst1_end", bus.ras_restore_valid, 0);

        // Stale tag is ignored
        bus.mispredict_valid = 1'b1;
        bus.mispredict_tag   = 3'd2;
        tick(); idle();
        chk("stale_restore", bus.ras_restore_valid, 0);
        chk("stale_count",   bus.ckpt_count, 1);
        chk("stale_ready",   bus.pred_ready, 1);

        // Commit and mispredict on the head entry together
        bus.commit_valid     = 1'b1;
        bus.mispredict_valid = 1'b1;
        bus.mispredict_tag   = 3'd0;
        tick(); idle();
        chk("cmmp_restore", bus.ras_restore_valid, 0);
        chk("cmmp_count",   bus.ckpt_count, 0);

        // Mispredict while recovering is ignored
        for (int i = 0; i < 3; i++) begin
            drive(OP_JAL, 5'd1, 5'd0, 32'h800 + 32'(i * 4), 3'(i + 4), 32'h900 + 32'(i));
            tick();
        end
        idle();
        chk("rec_fill", bus.ckpt_count, 3);
        bus.mispredict_valid = 1'b1;
        bus.mispredict_tag   = 3'd3;
        tick(); idle();
        chk("rec_valid", bus.ras_restore_valid, 1);
        chk("rec_ptr",   bus.ras_restore_ptr, 6);
        chk("rec_count", bus.ckpt_count, 2);
        bus.mispredict_valid = 1'b1;
        bus.mispredict_tag   = 3'd1;
        tick(); idle();
        chk("rec_ign_restore", bus.ras_restore_valid, 0);
        chk("rec_ign_count",   bus.ckpt_count, 2);

        // Reset during RECOVER aborts the restore
        bus.mispredict_valid = 1'b1;
        bus.mispredict_tag   = 3'd2;
        tick(); idle();
        chk("arst_pre_valid", bus.ras_restore_valid, 1);
        chk("arst_pre_count", bus.ckpt_count, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", bus.ras_restore_valid, 0);
        chk("arst_count", bus.ckpt_count, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("arst_ready",  bus.pred_ready, 1);
        chk("arst_count2", bus.ckpt_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
